// File: rtl/pe_row_scheduler_if.sv
// PE-side row handshake: the scheduler issues a row with pe_start and the
// PE array answers with pe_ready / pe_done.
interface pe_row_scheduler_if #(
  parameter int DATA_W = 208,
  parameter int IDX_W  = 5
);
  logic              pe_start;
  logic [DATA_W-1:0] pe_data;
  logic [IDX_W-1:0]  pe_row_idx;
  logic              pe_ready;
  logic              pe_done;

  modport master (
    output pe_start,
    output pe_data,
    output pe_row_idx,
    input  pe_ready,
    input  pe_done
  );

  modport slave (
    input  pe_start,
    input  pe_data,
    input  pe_row_idx,
    output pe_ready,
    output pe_done
  );
endinterface

// File: rtl/pe_row_scheduler.sv
// Buffers assembled camera rows in a small FIFO and issues them one at a time
// to the PE array, tracking row position within a frame and sticky errors.
module pe_row_scheduler #(
  parameter int DATA_W         = 208,
  parameter int DEPTH          = 4,
  parameter int ROWS_PER_FRAME = 24,
  parameter int TIMEOUT        = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr_err,
  input  logic                     din_vld,
  input  logic [DATA_W-1:0]        din,
  pe_row_scheduler_if.master       pe,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(ROWS_PER_FRAME);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FRAME_END} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PW:0]       count_q, count_d;
  logic [IW-1:0]     rowCnt_q, rowCnt_d, rowIdx_q, rowIdx_d;
  logic [TW-1:0]     toCnt_q, toCnt_d;
  logic [DATA_W-1:0] peData_q, peData_d;
  logic              overflow_q, overflow_d, timeoutErr_q, timeoutErr_d;
  logic              full, empty, pop, push, drop, timeoutEvt;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  // The head word is captured on entry to ISSUE, so the popped slot may be
  // overwritten by a same-cycle write into a full FIFO.
  assign pop   = (state_q == ISSUE);
  assign push  = din_vld && en && (!full || pop);
  assign drop  = din_vld && en && full && !pop;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= din;
  end

  always_comb begin
    state_d    = state_q;
    rowCnt_d   = rowCnt_q;
    rowIdx_d   = rowIdx_q;
    peData_d   = peData_q;
    toCnt_d    = '0;
    timeoutEvt = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !empty && pe.pe_ready) begin
          state_d  = ISSUE;
          peData_d = mem_q[rdPtr_q];
          rowIdx_d = rowCnt_q;
        end
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        toCnt_d = toCnt_q + TW'(1);
        // A pe_done landing on the expiry cycle is a normal completion.
        if (pe.pe_done || (toCnt_d == TW'(TIMEOUT))) begin
          timeoutEvt = !pe.pe_done;
          toCnt_d    = '0;
          if (rowCnt_q == IW'(ROWS_PER_FRAME - 1)) begin
            state_d = FRAME_END;
          end else begin
            rowCnt_d = rowCnt_q + IW'(1);
            state_d  = IDLE;
          end
        end
      end
      FRAME_END: begin
        rowCnt_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overflow_d   = (overflow_q && !clr_err) || drop;
  assign timeoutErr_d = (timeoutErr_q && !clr_err) || timeoutEvt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      rowCnt_q     <= '0;
      rowIdx_q     <= '0;
      toCnt_q      <= '0;
      peData_q     <= '0;
      overflow_q   <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      rowCnt_q     <= rowCnt_d;
      rowIdx_q     <= rowIdx_d;
      toCnt_q      <= toCnt_d;
      peData_q     <= peData_d;
      overflow_q   <= overflow_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign pe.pe_start   = (state_q == ISSUE);
  assign pe.pe_data    = peData_q;
  assign pe.pe_row_idx = rowIdx_q;
  assign frame_start   = (state_q == ISSUE) && (rowIdx_q == '0);
  assign frame_done    = (state_q == FRAME_END);
  assign fifo_level    = count_q;
  assign busy          = (state_q != IDLE);
  assign overflow      = overflow_q;
  assign timeout_err   = timeoutErr_q;

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Directed bench for pe_row_scheduler: inputs change and outputs are sampled
// 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_pe_row_scheduler;

  localparam int DATA_W = 208;
  localparam int DEPTH  = 4;
  localparam int ROWS   = 24;
  localparam int IW     = $clog2(ROWS);

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              clr_err;
  logic              din_vld;
  logic [DATA_W-1:0] din;
  logic              frame_start;
  logic              frame_done;
  logic [$clog2(DEPTH):0] fifo_level;
  logic              busy;
  logic              overflow;
  logic              timeout_err;

  int compareCount;
  int mismatchCount;
  int frameDoneCount;

  pe_row_scheduler_if #(.DATA_W(DATA_W), .IDX_W(IW)) peIf ();

  pe_row_scheduler #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS_PER_FRAME(ROWS), .TIMEOUT(1023)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr_err     (clr_err),
    .din_vld     (din_vld),
    .din         (din),
    .pe          (peIf),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rowWord(input logic [7:0] b);
    return {(DATA_W/8){b}};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) frameDoneCount++;
  endtask

  task automatic applyStimulus(input logic vld, input logic [DATA_W-1:0] data);
    din_vld = vld;
    din     = data;
    tick();
    din_vld = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    en = 1'b0; clr_err = 1'b0; din_vld = 1'b0; din = '0;
    peIf.pe_ready = 1'b0; peIf.pe_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    frameDoneCount = 0;
  endtask

  task automatic completeRow();
    peIf.pe_done = 1'b1;
    tick();
    peIf.pe_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compareCount   = 0;
    mismatchCount  = 0;
    frameDoneCount = 0;

    doReset();
    checkOutput("rst_pe_start", peIf.pe_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_pe_data", peIf.pe_data, 0);
    checkOutput("rst_flags", {overflow, timeout_err, frame_done, frame_start}, 0);

    // Single row: two-cycle latency from din_vld to pe_start.
    en = 1'b1; peIf.pe_ready = 1'b1;
    applyStimulus(1'b1, rowWord(8'hA5));
    checkOutput("single_level", fifo_level, 1);
    checkOutput("single_early_start", peIf.pe_start, 0);
    tick();
    checkOutput("single_start", peIf.pe_start, 1);
    checkOutput("single_data", peIf.pe_data, rowWord(8'hA5));
    checkOutput("single_idx", peIf.pe_row_idx, 0);
    checkOutput("single_frame_start", frame_start, 1);
    tick();
    checkOutput("single_start_pulse", peIf.pe_start, 0);
    checkOutput("single_busy_wait", busy, 1);
    checkOutput("single_level_popped", fifo_level, 0);
    checkOutput("single_data_held", peIf.pe_data, rowWord(8'hA5));
    completeRow();
    checkOutput("single_idle", busy, 0);

    // Full frame with pe_done five cycles after each pe_start.
    doReset();
    en = 1'b1; peIf.pe_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      applyStimulus(1'b1, rowWord(8'(r)));
      tick();
      checkOutput("frame_start_strobe", peIf.pe_start, 1);
      checkOutput("frame_idx", peIf.pe_row_idx, 256'(r));
      checkOutput("frame_fs", frame_start, (r == 0));
      checkOutput("frame_data", peIf.pe_data, rowWord(8'(r)));
      repeat (5) tick();
      completeRow();
      if (r == ROWS - 1) checkOutput("frame_done_pulse", frame_done, 1);
      else               checkOutput("frame_row_idle", busy, 0);
    end
    tick();
    checkOutput("frame_done_end", frame_done, 0);
    checkOutput("frame_done_count", frameDoneCount, 1);
    checkOutput("frame_idle_after", busy, 0);
    applyStimulus(1'b1, rowWord(8'h77));
    tick();
    checkOutput("next_frame_fs", frame_start, 1);
    checkOutput("next_frame_idx", peIf.pe_row_idx, 0);
    tick();
    completeRow();

    // Overflow: five writes into a stalled four-deep FIFO.
    doReset();
    en = 1'b1; peIf.pe_ready = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, rowWord(8'(8'h40 + k)));
    checkOutput("ovf_level", fifo_level, 4);
    checkOutput("ovf_flag", overflow, 1);
    din_vld = 1'b1; clr_err = 1'b1;
    tick();
    din_vld = 1'b0; clr_err = 1'b0;
    checkOutput("ovf_clr_collision", overflow, 1);
    peIf.pe_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("ovf_issue_start", peIf.pe_start, 1);
      checkOutput("ovf_issue_data", peIf.pe_data, rowWord(8'(8'h40 + k)));
      tick();
      completeRow();
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("ovf_no_fifth", busy, 0);
    end
    checkOutput("ovf_drained", fifo_level, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("ovf_cleared", overflow, 0);

    // Full FIFO accepts a write in the ISSUE cycle thanks to the pop.
    doReset();
    en = 1'b1; peIf.pe_ready = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, rowWord(8'(8'h60 + k)));
    checkOutput("pop_full_level", fifo_level, 4);
    peIf.pe_ready = 1'b1;
    tick();
    checkOutput("pop_issue", peIf.pe_start, 1);
    applyStimulus(1'b1, rowWord(8'h6E));
    checkOutput("pop_level_kept", fifo_level, 4);
    checkOutput("pop_no_overflow", overflow, 0);
    completeRow();
    for (int k = 1; k < 5; k++) begin
      tick();
      checkOutput("pop_order", peIf.pe_data,
                  (k < 4) ? rowWord(8'(8'h60 + k)) : rowWord(8'h6E));
      tick();
      completeRow();
    end

    // Timeout: no pe_done for a full window, then pe_done on the last cycle.
    doReset();
    en = 1'b1; peIf.pe_ready = 1'b1;
    applyStimulus(1'b1, rowWord(8'h80));
    applyStimulus(1'b1, rowWord(8'h81));
    checkOutput("to_issue0", peIf.pe_start, 1);
    tick();
    repeat (1022) tick();
    checkOutput("to_not_yet", timeout_err, 0);
    checkOutput("to_still_busy", busy, 1);
    tick();
    checkOutput("to_flag", timeout_err, 1);
    checkOutput("to_advanced", busy, 0);
    tick();
    checkOutput("to_next_start", peIf.pe_start, 1);
    checkOutput("to_next_data", peIf.pe_data, rowWord(8'h81));
    checkOutput("to_next_idx", peIf.pe_row_idx, 1);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("to_cleared", timeout_err, 0);
    repeat (1021) tick();
    completeRow();
    checkOutput("to_coincide_noerr", timeout_err, 0);
    checkOutput("to_coincide_idle", busy, 0);

    // Enable drop mid-row, then asynchronous reset during WAIT_DONE.
    doReset();
    en = 1'b1; peIf.pe_ready = 1'b1;
    applyStimulus(1'b1, rowWord(8'h90));
    applyStimulus(1'b1, rowWord(8'h91));
    tick();
    en = 1'b0;
    applyStimulus(1'b1, rowWord(8'h9F));
    checkOutput("en_ignored_level", fifo_level, 1);
    checkOutput("en_ignored_ovf", overflow, 0);
    checkOutput("en_row_busy", busy, 1);
    completeRow();
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("en_hold_idle", busy, 0);
    end
    checkOutput("en_retained", fifo_level, 1);
    en = 1'b1;
    tick();
    checkOutput("en_resume_data", peIf.pe_data, rowWord(8'h91));
    checkOutput("en_resume_idx", peIf.pe_row_idx, 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", busy, 0);
    checkOutput("async_level", fifo_level, 0);
    checkOutput("async_data", peIf.pe_data, 0);
    checkOutput("async_idx", peIf.pe_row_idx, 0);
    checkOutput("async_outs", {peIf.pe_start, frame_start, frame_done}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/pe_row_scheduler.md
Name: pe_row_scheduler

Overview:
- Sits between top_input's 208-bit parallel output (parallel_data/dout_vald) and the PE array.
- Buffers assembled camera rows in a small FIFO and issues them to the PE array one at a time with a start/done handshake.
- Counts rows per frame and flags frame boundaries.
- Reports overflow and PE-timeout errors.

Parameters:
- DATA_W, 208, width of one parallel row word (26 bytes).
- DEPTH, 4, FIFO depth in words; power of 2, min 2.
- ROWS_PER_FRAME, 24, rows forming one frame.
- TIMEOUT, 1023, max cycles waiting for pe_done before forced completion.

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable.
- clr_err  in  1  clears sticky error flags.
- din_vld  in  1  one-cycle strobe; din holds a valid row (already synchronous to clk).
- din  in  DATA_W  row word.
- pe_ready  in  1  PE array can accept a row.
- pe_done  in  1  one-cycle strobe; PE finished the current row.
- pe_start  out  1  one-cycle issue strobe.
- pe_data  out  DATA_W  row word, held stable from pe_start until the next issue.
- pe_row_idx  out  $clog2(ROWS_PER_FRAME)  index of the issued row.
- frame_start  out  1  pulse, coincident with pe_start of row 0.
- frame_done  out  1  one-cycle pulse after the last row's completion.
- fifo_level  out  $clog2(DEPTH)+1  words currently buffered.
- busy  out  1  high in any state except IDLE.
- overflow  out  1  sticky; a write was dropped.
- timeout_err  out  1  sticky; a PE row timed out.

Behaviour:
- Reset:
  - All outputs 0; pe_data 0.
  - FIFO emptied; row counter 0; FSM in IDLE.
  - Reset mid-row abandons the row; no frame_done is generated.
- FIFO write:
  - Write occurs when din_vld && en && (!full || pop in the same cycle).
  - If din_vld && en && full with no pop: word dropped and overflow set.
  - din_vld while en=0 is ignored and does not set overflow.
  - fifo_level updates the cycle after a write or pop; simultaneous write and pop leaves it unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_DONE, FRAME_END.
  - IDLE -> ISSUE when en && !empty && pe_ready.
  - ISSUE (1 cycle):
    - pe_start=1, pe_data loaded from FIFO head, FIFO popped.
    - pe_row_idx = row counter; frame_start=1 if the row counter is 0.
    - Next state WAIT_DONE.
  - WAIT_DONE:
    - Timeout counter increments each cycle.
    - On pe_done, or when the counter reaches TIMEOUT (which also sets timeout_err): if row counter == ROWS_PER_FRAME-1, go to FRAME_END; else increment the row counter and go to IDLE.
    - Timeout counter clears on exit.
  - FRAME_END (1 cycle): frame_done=1, row counter <- 0, then IDLE.
- Latency:
  - din_vld into an empty FIFO with pe_ready=1 and FSM in IDLE: pe_start asserts 2 cycles later (1 cycle write, 1 cycle IDLE decision).
  - Back-to-back rows: pe_done to next pe_start is a minimum of 2 cycles (IDLE, ISSUE); 3 at a frame end.
- Handshake edge rules:
  - pe_done outside WAIT_DONE is ignored.
  - pe_done in the same cycle the counter hits TIMEOUT counts as normal completion; no error.
- en deassert mid-row: the current row completes normally; no new issue until en returns. FIFO contents and row counter are retained.
- clr_err clears overflow and timeout_err. A new error in the same cycle wins: the flag stays set.
- busy = (state != IDLE).

Test Plan:
- Single row: reset, en=1, pe_ready=1, one din_vld with din=208'hA5... -> pe_start 2 cycles later, pe_data=A5..., pe_row_idx=0, frame_start=1, busy=1 until pe_done.
- Full frame: 24 rows, pe_done 5 cycles after each pe_start -> pe_row_idx steps 0..23; frame_done pulses once, 1 cycle after the 24th pe_done; row counter returns to 0; next row has frame_start=1.
- Overflow: pe_ready=0, 5 din_vld strobes with DEPTH=4 -> fifo_level=4, overflow=1. Release pe_ready -> exactly the first 4 words are issued in order. clr_err -> overflow=0.
- Full with simultaneous pop: FIFO full, din_vld in the ISSUE cycle -> word accepted, fifo_level stays 4, overflow stays 0.
- Timeout: pe_done never asserted -> after 1023 WAIT_DONE cycles timeout_err=1, FSM advances, next row issued. pe_done coinciding with cycle 1023 -> no error.
- Reset/enable: rst_n low in WAIT_DONE -> all outputs 0 immediately (asynchronous), FIFO empty. en=0 during WAIT_DONE -> row completes; queued rows are not issued until en=1.
